// File: rtl/ram_param.sv
// ram_param: single-port synchronous RAM with a self-clearing start-up sequence.
// After reset the array is zeroed one word per cycle (busy high, requests
// ignored); afterwards one read and/or one write per cycle is serviced on the
// shared address, with registered read data and a one-cycle rvalid pulse.
// Optional build macro RAM_WR_BYPASS_EN: a same-cycle read and write returns
// the new write data (write-first) instead of the stored word (read-first).
module ram_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] out,
  output logic              rvalid,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                rvalid_q, rvalid_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Next-state, clear-pointer, read-data and memory write-port selection.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    out_d     = out_q;
    rvalid_d  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = wdata;
    unique case (state_q)
      CLEAR: begin
        mem_we    = !rst;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        // The pointer stops on the last word rather than wrapping.
        if (ptr_q == '1) begin
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        mem_we = MemWrite && !rst;
        if (MemRead) begin
          rvalid_d = 1'b1;
`ifdef RAM_WR_BYPASS_EN
          out_d = MemWrite ? wdata : mem[addr];
`else
          out_d = mem[addr];
`endif
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Control and read-data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CLEAR;
      ptr_q    <= '0;
      out_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      out_q    <= out_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Storage array; only the clear sequence zeroes it, reset does not.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign out    = out_q;
  assign rvalid = rvalid_q;
  assign busy   = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_param.sv
// Testbench for ram_param (DATA_W=8, ADDR_W=8): clear timing, mid-clear reset,
// full-array zero sweep, directed vector table and randomized traffic against
// an array-based reference model.
module tb_ram_param;

`ifdef RAM_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, MemWrite, MemRead;
  logic [7:0] addr, wdata, out;
  logic       rvalid, busy;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  logic [7:0] model_mem [256];
  logic [7:0] m_out;
  logic       m_rv;

  ram_param #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .MemWrite(MemWrite), .MemRead(MemRead),
    .addr(addr), .wdata(wdata), .out(out), .rvalid(rvalid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic       re;
    logic [7:0] a;
    logic [7:0] d;
    logic       exp_rv;
    logic [7:0] exp_out;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One IDLE-mode operation: drive, clock, and advance the reference model.
  task automatic op(input logic we, input logic re, input logic [7:0] a, input logic [7:0] d);
    MemWrite = we; MemRead = re; addr = a; wdata = d;
    step();
    if (re) begin
      m_out = (BYP && we) ? d : model_mem[a];
      m_rv  = 1'b1;
    end else begin
      m_rv = 1'b0;
    end
    if (we) model_mem[a] = d;
    MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  initial begin
    vec_t vecs[9];
    int unsigned busy_cycles;
    int unsigned rv_during_busy;

    rst = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; addr = '0; wdata = '0;
    step();
    check("reset_busy", busy, 1'b1);
    check("reset_rvalid", rvalid, 1'b0);
    check("reset_out", out, 8'h00);

    // Run part of a clear with ignored requests, then reset mid-clear.
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      MemWrite = 1'b1; MemRead = 1'b1; addr = 8'h55; wdata = 8'h99;
      step();
    end
    check("midclear_busy", busy, 1'b1);
    rst = 1'b1;
    step();
    check("rst_mid_out", out, 8'h00);
    check("rst_mid_rvalid", rvalid, 1'b0);
    check("rst_mid_busy", busy, 1'b1);
    rst = 1'b0;

    // Count clear cycles while requesting a write of 0x7E to 0xFF.
    busy_cycles = 0;
    rv_during_busy = 0;
    for (int i = 0; i < 300; i++) begin
      MemWrite = 1'b1; MemRead = 1'b1; addr = 8'hFF; wdata = 8'h7E;
      step();
      busy_cycles++;
      if (rvalid) rv_during_busy++;
      if (!busy) break;
    end
    MemWrite = 1'b0; MemRead = 1'b0;
    check("clear_cycles", busy_cycles, 256);
    check("rvalid_during_busy", rv_during_busy, 0);
    check("busy_after_clear", busy, 1'b0);

    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    m_out = 8'h00; m_rv = 1'b0;

    // Every word must read back as zero.
    for (int i = 0; i < 256; i++) begin
      op(1'b0, 1'b1, 8'(i), 8'h00);
      check($sformatf("sweep_out[%0d]", i), out, 8'h00);
      check($sformatf("sweep_rv[%0d]", i), rvalid, 1'b1);
    end

    vecs[0] = '{1'b1, 1'b0, 8'h10, 8'hA5, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 8'h10, 8'h00, 1'b1, 8'hA5};
    vecs[2] = '{1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 8'hA5};
    vecs[3] = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 8'h20, 8'h11, 1'b0, 8'h00};
    vecs[5] = '{1'b1, 1'b1, 8'h20, 8'h22, 1'b1, (BYP ? 8'h22 : 8'h11)};
    vecs[6] = '{1'b0, 1'b1, 8'h20, 8'h00, 1'b1, 8'h22};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h22};
    vecs[8] = '{1'b0, 1'b1, 8'h10, 8'h00, 1'b1, 8'hA5};
    for (int i = 0; i < 9; i++) begin
      op(vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].d);
      check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
      check($sformatf("vec%0d_rvalid", i), rvalid, vecs[i].exp_rv);
    end

    // Randomized traffic on a small address window to force reuse.
    for (int i = 0; i < 400; i++) begin
      op(1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
      check($sformatf("rnd%0d_out", i), out, m_out);
      check($sformatf("rnd%0d_rvalid", i), rvalid, m_rv);
      check($sformatf("rnd%0d_busy", i), busy, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
